// File: rtl/irda_mode_ctrl_pkg.sv
// Shared definitions for the IrDA SIR <-> FIR/MIR mode switch sequencer:
// FSM state encoding and mode select constants.
package irda_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4
  } mode_state_e;

  localparam logic MODE_SIR  = 1'b0;
  localparam logic MODE_FAST = 1'b1;

endpackage

// File: rtl/irda_mode_ctrl.sv
// Sequences a switch between the SIR and fast sub-cores: drains the host bus
// and the IR line, pulses the transceiver mode pins, then flips the router select.
module irda_mode_ctrl
  import irda_mode_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 8,
  parameter int HOLD_CYC   = 8,
  parameter int SETTLE_CYC = 64,
  parameter int CNT_W      = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic mode_req,
  input  logic wb_cyc_i,
  input  logic wb_ack_o,
  input  logic tx_busy,
  input  logic rx_active,
  output logic fast_mode,
  output logic bus_hold,
  output logic xcvr_sd,
  output logic xcvr_mode,
  output logic switching,
  output logic mode_done
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  mode_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             fast_mode_q, fast_mode_d;
  logic             bus_hold_q, bus_hold_d;
  logic             xcvr_sd_q, xcvr_sd_d;
  logic             xcvr_mode_q, xcvr_mode_d;
  logic             mode_done_q, mode_done_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      target_q    <= MODE_SIR;
      fast_mode_q <= MODE_SIR;
      bus_hold_q  <= 1'b0;
      xcvr_sd_q   <= 1'b0;
      xcvr_mode_q <= MODE_SIR;
      mode_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      fast_mode_q <= fast_mode_d;
      bus_hold_q  <= bus_hold_d;
      xcvr_sd_q   <= xcvr_sd_d;
      xcvr_mode_q <= xcvr_mode_d;
      mode_done_q <= mode_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    fast_mode_d = fast_mode_q;
    bus_hold_d  = bus_hold_q;
    xcvr_sd_d   = xcvr_sd_q;
    xcvr_mode_d = xcvr_mode_q;
    mode_done_d = 1'b0;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    unique case (state_q)
      ST_RUN: begin
        bus_hold_d = 1'b0;
        if (mode_req != fast_mode_q) begin
          target_d = mode_req;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Until the bus is held the request may still be withdrawn; afterwards
        // the latched target is committed.
        if (!bus_hold_q) begin
          if (mode_req == fast_mode_q) begin
            state_d = ST_RUN;
          end else if (!wb_cyc_i || wb_ack_o) begin
            bus_hold_d = 1'b1;
          end
        end else if (!tx_busy && !rx_active) begin
          state_d     = ST_SETUP;
          xcvr_sd_d   = 1'b1;
          xcvr_mode_d = target_q;
          cnt_d       = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          xcvr_sd_d = 1'b0;
          cnt_d     = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_SETTLE;
          fast_mode_d = target_q;
          cnt_d       = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d     = ST_RUN;
          bus_hold_d  = 1'b0;
          mode_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        bus_hold_d = 1'b0;
      end
    endcase
  end

  assign fast_mode = fast_mode_q;
  assign bus_hold  = bus_hold_q;
  assign xcvr_sd   = xcvr_sd_q;
  assign xcvr_mode = xcvr_mode_q;
  assign mode_done = mode_done_q;
  assign switching = (state_q != ST_RUN);

endmodule

// File: tb/tb_irda_mode_ctrl.sv
// Directed bench for irda_mode_ctrl: default instance for the main sequences,
// a second instance with SETTLE_CYC=1 for the short fast->SIR return.
module tb_irda_mode_ctrl;
  import irda_mode_ctrl_pkg::*;

  logic clk;
  logic rst, rst2;
  logic mode_req, mode_req2;
  logic cyc, ack, tx_busy, rx_active;
  logic fast_mode, bus_hold, xcvr_sd, xcvr_mode, switching, mode_done;
  logic fast_mode2, bus_hold2, xcvr_sd2, xcvr_mode2, switching2, mode_done2;

  int checks = 0;
  int errors = 0;
  int n;

  localparam int FULL_STEPS  = 2 + 8 + 8 + 64 + 1; // request edge counts as step 1
  localparam int SHORT_STEPS = 2 + 8 + 8 + 1 + 1;

  irda_mode_ctrl dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),      .mode_req (mode_req),
    .wb_cyc_i (cyc),       .wb_ack_o (ack),      .tx_busy  (tx_busy),
    .rx_active(rx_active), .fast_mode(fast_mode), .bus_hold(bus_hold),
    .xcvr_sd  (xcvr_sd),   .xcvr_mode(xcvr_mode), .switching(switching),
    .mode_done(mode_done)
  );

  irda_mode_ctrl #(.SETTLE_CYC(1)) dut_s1 (
    .wb_clk_i (clk),        .wb_rst_i (rst2),       .mode_req (mode_req2),
    .wb_cyc_i (cyc),        .wb_ack_o (ack),        .tx_busy  (tx_busy),
    .rx_active(rx_active),  .fast_mode(fast_mode2), .bus_hold(bus_hold2),
    .xcvr_sd  (xcvr_sd2),   .xcvr_mode(xcvr_mode2), .switching(switching2),
    .mode_done(mode_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until the selected instance pulses mode_done; returns steps taken.
  task automatic wait_done(input bit sel, input int max, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < max) begin
      step();
      cnt++;
      seen = sel ? (mode_done2 === 1'b1) : (mode_done === 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    mode_req = MODE_SIR; mode_req2 = MODE_SIR;
    cyc = 1'b0; ack = 1'b0; tx_busy = 1'b0; rx_active = 1'b0;
    repeat (3) step();
    chk("rst_fast_mode", fast_mode, 0);
    chk("rst_bus_hold",  bus_hold,  0);
    chk("rst_xcvr_sd",   xcvr_sd,   0);
    chk("rst_xcvr_mode", xcvr_mode, 0);
    chk("rst_switching", switching, 0);
    chk("rst_mode_done", mode_done, 0);
    rst = 1'b0;
    step();

    // Idle switch SIR -> fast with exact edge timing
    mode_req = MODE_FAST;
    step(); // edge 0
    chk("idle_e0_switching", switching, 1);
    chk("idle_e0_bus_hold",  bus_hold,  0);
    step(); // edge 1
    chk("idle_e1_bus_hold", bus_hold, 1);
    chk("idle_e1_xcvr_sd",  xcvr_sd,  0);
    step(); // edge 2
    chk("idle_e2_xcvr_sd",   xcvr_sd,   1);
    chk("idle_e2_xcvr_mode", xcvr_mode, 1);
    chk("idle_e2_fast_mode", fast_mode, 0);
    repeat (7) step(); // edge 9
    chk("idle_e9_xcvr_sd", xcvr_sd, 1);
    step(); // edge 10
    chk("idle_e10_xcvr_sd",   xcvr_sd,   0);
    chk("idle_e10_xcvr_mode", xcvr_mode, 1);
    repeat (7) step(); // edge 17
    chk("idle_e17_fast_mode", fast_mode, 0);
    step(); // edge 18
    chk("idle_e18_fast_mode", fast_mode, 1);
    chk("idle_e18_bus_hold",  bus_hold,  1);
    repeat (63) step(); // edge 81
    chk("idle_e81_mode_done", mode_done, 0);
    chk("idle_e81_switching", switching, 1);
    step(); // edge 82
    chk("idle_e82_mode_done", mode_done, 1);
    chk("idle_e82_bus_hold",  bus_hold,  0);
    chk("idle_e82_switching", switching, 0);
    step();
    chk("idle_done_pulse_end", mode_done, 0);
    chk("idle_xcvr_mode_level", xcvr_mode, 1);

    // Transfer in flight: hold waits for the ack edge
    cyc = 1'b1; ack = 1'b0; mode_req = MODE_SIR;
    repeat (6) step(); // edges 0..5
    chk("xfer_no_hold_before_ack", bus_hold, 0);
    chk("xfer_switching", switching, 1);
    ack = 1'b1;
    step();
    chk("xfer_hold_on_ack", bus_hold, 1);
    chk("xfer_sd_not_yet", xcvr_sd, 0);
    ack = 1'b0; cyc = 1'b0;
    step();
    chk("xfer_setup_next", xcvr_sd, 1);
    chk("xfer_xcvr_mode",  xcvr_mode, 0);
    wait_done(1'b0, 200, n);
    chk("xfer_remaining_steps", n, 8 + 8 + 64);
    chk("xfer_fast_mode", fast_mode, 0);

    // Line busy: stay in DRAIN until both activity flags drop
    tx_busy = 1'b1; mode_req = MODE_FAST;
    step(); step();
    chk("busy_hold", bus_hold, 1);
    repeat (100) step();
    chk("busy_still_switching", switching, 1);
    chk("busy_xcvr_sd",   xcvr_sd,   0);
    chk("busy_fast_mode", fast_mode, 0);
    chk("busy_bus_hold",  bus_hold,  1);
    tx_busy = 1'b0; rx_active = 1'b1;
    step();
    chk("busy_rx_blocks", xcvr_sd, 0);
    rx_active = 1'b0;
    step();
    chk("busy_setup_after_idle", xcvr_sd, 1);
    wait_done(1'b0, 200, n);
    chk("busy_remaining_steps", n, 8 + 8 + 64);
    chk("busy_fast_mode_end", fast_mode, 1);

    // Cancel while a transfer is open
    cyc = 1'b1; mode_req = MODE_SIR;
    step();
    chk("cancel_drain", switching, 1);
    mode_req = MODE_FAST;
    step();
    chk("cancel_back_run", switching, 0);
    chk("cancel_bus_hold", bus_hold,  0);
    chk("cancel_mode_done", mode_done, 0);
    chk("cancel_xcvr_sd",   xcvr_sd,   0);
    chk("cancel_xcvr_mode", xcvr_mode, 1);
    chk("cancel_fast_mode", fast_mode, 1);
    repeat (4) step();
    chk("cancel_no_pulse", mode_done, 0);
    cyc = 1'b0;

    // Fast -> SIR on the default instance
    mode_req = MODE_SIR;
    wait_done(1'b0, 200, n);
    chk("f2s_steps", n, FULL_STEPS);
    chk("f2s_fast_mode", fast_mode, 0);
    chk("f2s_xcvr_mode", xcvr_mode, 0);
    step();
    chk("f2s_xcvr_mode_held", xcvr_mode, 0);

    // Reset in the middle of SETTLE
    mode_req = MODE_FAST;
    repeat (41) step(); // edges 0..40
    chk("mid_settle_fast_mode", fast_mode, 1);
    chk("mid_settle_bus_hold",  bus_hold,  1);
    rst = 1'b1;
    #1;
    chk("arst_fast_mode", fast_mode, 0);
    chk("arst_bus_hold",  bus_hold,  0);
    chk("arst_xcvr_mode", xcvr_mode, 0);
    chk("arst_xcvr_sd",   xcvr_sd,   0);
    chk("arst_switching", switching, 0);
    step(); step();
    rst = 1'b0;
    wait_done(1'b0, 200, n);
    chk("restart_steps", n, FULL_STEPS);
    chk("restart_fast_mode", fast_mode, 1);

    // Short-settle instance: SIR -> fast -> SIR
    rst2 = 1'b0;
    step();
    mode_req2 = MODE_FAST;
    wait_done(1'b1, 100, n);
    chk("s1_up_steps", n, SHORT_STEPS);
    chk("s1_up_fast_mode", fast_mode2, 1);
    mode_req2 = MODE_SIR;
    wait_done(1'b1, 100, n);
    chk("s1_down_steps", n, SHORT_STEPS);
    chk("s1_down_fast_mode", fast_mode2, 0);
    chk("s1_down_bus_hold",  bus_hold2,  0);
    repeat (3) step();
    chk("s1_xcvr_mode_held", xcvr_mode2, 0);
    chk("s1_no_extra_pulse", mode_done2, 0);
    chk("s1_switching",      switching2, 0);
    chk("s1_xcvr_sd",        xcvr_sd2,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
